// File: rtl/instr_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_responder_if
// Purpose  : Request/response bundle between the fetch stage and the
//            multi-cycle instruction-memory responder.
// Revision : 1.0  initial release
// ============================================================================
interface instr_mem_responder_if;
  logic        req;
  logic [15:0] addr;
  logic        wr;
  logic [15:0] wdata;
  logic        flush;
  logic [15:0] data_out;
  logic        done;
  logic        stall;
  logic        err;

  modport master (
    output req, addr, wr, wdata, flush,
    input  data_out, done, stall, err
  );

  modport slave (
    input  req, addr, wr, wdata, flush,
    output data_out, done, stall, err
  );
endinterface
`default_nettype wire

// File: rtl/instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_responder
// Purpose  : Multi-cycle instruction memory with stall/done handshake, branch
//            flush of in-flight reads, and a preload write path.
// Revision : 1.0  initial release
// ============================================================================
module instr_mem_responder #(
  parameter int ADDR_W = 10,
  parameter int LAT    = 3
) (
  input  wire logic      clk,
  input  wire logic      rst,
  instr_mem_responder_if.slave bus
);

  localparam logic [1:0]  c_IDLE     = 2'd0;
  localparam logic [1:0]  c_BUSY     = 2'd1;
  localparam logic [1:0]  c_DONE     = 2'd2;
  localparam logic [15:0] c_NOP      = 16'h0800;
  localparam logic [3:0]  c_CNT_LOAD = (LAT > 1) ? 4'(LAT - 2) : 4'd0;

  logic [1:0]      r_state;
  logic [1:0]      w_nextState;
  logic [3:0]      r_cnt;
  logic [3:0]      w_nextCnt;
  logic [ADDR_W:0] r_addr;
  logic            r_wr;
  logic [15:0]     r_wdata;
  logic [15:0]     r_mem [2**ADDR_W];

  logic            w_accept;
  logic            w_complete;
  logic [ADDR_W:0] w_cmpAddr;
  logic            w_cmpWr;
  logic [15:0]     w_cmpWdata;
  logic [ADDR_W-1:0] w_idx;
  logic            w_memWe;

  logic [15:0]     r_dataOut;
  logic            r_done;
  logic            r_stall;
  logic            r_err;

  // Address bits above the word index only alias; they are never decoded.
  generate
    if (ADDR_W < 15) begin : g_hiBits
      logic w_unusedAddrHi;
      assign w_unusedAddrHi = ^bus.addr[15:ADDR_W+1];
    end
  endgenerate

  // w_cmp* describe the request that completes at this edge: the captured one
  // when leaving BUSY, or the live bus request when LAT=1 skips BUSY.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    w_cmpAddr   = r_addr;
    w_cmpWr     = r_wr;
    w_cmpWdata  = r_wdata;
    case (r_state)
      c_BUSY: begin
        if (bus.flush && !r_wr) begin
          w_nextState = c_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_nextState = c_DONE;
          w_complete  = 1'b1;
        end else begin
          w_nextCnt = r_cnt - 4'd1;
        end
      end
      default: begin
        if (bus.req && !bus.flush) begin
          w_accept = 1'b1;
          if (LAT == 1) begin
            w_nextState = c_DONE;
            w_complete  = 1'b1;
            w_cmpAddr   = bus.addr[ADDR_W:0];
            w_cmpWr     = bus.wr;
            w_cmpWdata  = bus.wdata;
          end else begin
            w_nextState = c_BUSY;
            w_nextCnt   = c_CNT_LOAD;
          end
        end else begin
          w_nextState = c_IDLE;
        end
      end
    endcase
  end

  assign w_idx   = w_cmpAddr[ADDR_W:1];
  // Gated by rst so a write racing an asserted reset is dropped.
  assign w_memWe = w_complete && w_cmpWr && !w_cmpAddr[0] && rst;

  always_ff @(posedge clk) begin
    if (w_memWe) begin
      r_mem[w_idx] <= w_cmpWdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= c_IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_wr      <= 1'b0;
      r_wdata   <= 16'h0000;
      r_dataOut <= 16'h0000;
      r_done    <= 1'b0;
      r_stall   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (w_accept) begin
        r_addr  <= bus.addr[ADDR_W:0];
        r_wr    <= bus.wr;
        r_wdata <= bus.wdata;
      end
      r_done  <= w_complete;
      r_stall <= (w_nextState == c_BUSY);
      r_err   <= w_complete && w_cmpAddr[0];
      if (w_complete) begin
        if (w_cmpAddr[0]) begin
          r_dataOut <= c_NOP;
        end else if (w_cmpWr) begin
          r_dataOut <= 16'h0000;
        end else begin
          r_dataOut <= r_mem[w_idx];
        end
      end
    end
  end

  assign bus.data_out = r_dataOut;
  assign bus.done     = r_done;
  assign bus.stall    = r_stall;
  assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_responder
// Purpose  : Drives a LAT=3 and a LAT=1 responder with shared stimulus and
//            compares both against a transaction-level model every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_mem_responder;

  logic clk;
  logic rst;
  instr_mem_responder_if bus3();
  instr_mem_responder_if bus1();

  instr_mem_responder #(.ADDR_W(10), .LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
  instr_mem_responder #(.ADDR_W(10), .LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrs   = 0;
  bit chkEn   = 1'b0;
  int edgeN   = 0;
  int latOf [2] = '{3, 1};

  // Model: a request finishes at edge (accept + LAT - 1); nothing else is tracked.
  bit          mInflight [2];
  int          mDoneEdge [2];
  logic [15:0] mAddr [2];
  logic [15:0] mWdata [2];
  bit          mWr [2];
  logic [15:0] mMem [2][1024];
  bit          eDone [2];
  bit          eStall [2];
  bit          eErr [2];
  logic [15:0] eData [2];
  logic [15:0] pre [64];

  task automatic chk(string nm, int d, logic [15:0] got, logic [15:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrs++;
      $display("FAIL %s dut%0d t=%0t got=%h exp=%h", nm, d, $time, got, exp);
    end
  endtask

  function automatic void mReset(int d);
    mInflight[d] = 1'b0;
    eDone[d]  = 1'b0;
    eStall[d] = 1'b0;
    eErr[d]   = 1'b0;
    eData[d]  = 16'h0000;
  endfunction

  function automatic void mComplete(int d, bit w, logic [15:0] a, logic [15:0] wd);
    int idx;
    idx = (int'(a) >> 1) % 1024;
    eDone[d] = 1'b1;
    if (a[0]) begin
      eData[d] = 16'h0800;
      eErr[d]  = 1'b1;
    end else if (w) begin
      mMem[d][idx] = wd;
      eData[d] = 16'h0000;
    end else begin
      eData[d] = mMem[d][idx];
    end
  endfunction

  function automatic void mStep(int d, bit rq, bit w, logic [15:0] a, logic [15:0] wd, bit fl);
    eDone[d] = 1'b0;
    eErr[d]  = 1'b0;
    if (mInflight[d]) begin
      if (fl && !mWr[d]) begin
        mInflight[d] = 1'b0;
      end else if (edgeN == mDoneEdge[d]) begin
        mInflight[d] = 1'b0;
        mComplete(d, mWr[d], mAddr[d], mWdata[d]);
      end
    end else if (rq && !fl) begin
      mWr[d] = w; mAddr[d] = a; mWdata[d] = wd;
      if (latOf[d] == 1) begin
        mComplete(d, w, a, wd);
      end else begin
        mInflight[d] = 1'b1;
        mDoneEdge[d] = edgeN + latOf[d] - 1;
      end
    end
    eStall[d] = mInflight[d];
  endfunction

  task automatic cyc(bit rq, bit w, logic [15:0] a, logic [15:0] wd, bit fl);
    bus3.req = rq; bus3.wr = w; bus3.addr = a; bus3.wdata = wd; bus3.flush = fl;
    bus1.req = rq; bus1.wr = w; bus1.addr = a; bus1.wdata = wd; bus1.flush = fl;
    @(posedge clk);
    edgeN++;
    for (int d = 0; d < 2; d++) begin
      if (!rst) mReset(d);
      else      mStep(d, rq, w, a, wd, fl);
    end
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
  endtask

  // Issue one request and wait until the LAT=3 unit sits in its DONE cycle.
  task automatic doReq(bit w, logic [15:0] a, logic [15:0] wd);
    cyc(1'b1, w, a, wd, 1'b0);
    idle();
    idle();
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      chk("done",  0, 16'(bus3.done),  16'(eDone[0]));
      chk("stall", 0, 16'(bus3.stall), 16'(eStall[0]));
      chk("err",   0, 16'(bus3.err),   16'(eErr[0]));
      chk("data",  0, bus3.data_out,   eData[0]);
      chk("done",  1, 16'(bus1.done),  16'(eDone[1]));
      chk("stall", 1, 16'(bus1.stall), 16'(eStall[1]));
      chk("err",   1, 16'(bus1.err),   16'(eErr[1]));
      chk("data",  1, bus1.data_out,   eData[1]);
    end
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rd;
    logic [5:0]  ri;
    logic [4:0]  rh;
    bus3.req = 0; bus3.wr = 0; bus3.addr = 0; bus3.wdata = 0; bus3.flush = 0;
    bus1.req = 0; bus1.wr = 0; bus1.addr = 0; bus1.wdata = 0; bus1.flush = 0;
    rst = 1'b1;
    mReset(0); mReset(1);
    #2 rst = 1'b0;
    #1;
    chk("rst_data", 0, bus3.data_out, 16'h0000);
    chk("rst_stall", 0, 16'(bus3.stall), 16'h0000);
    chk("rst_done", 1, 16'(bus1.done), 16'h0000);
    chkEn = 1'b1;
    @(posedge clk); #1;
    idle(); idle();
    rst = 1'b1;

    for (int i = 0; i < 64; i++) begin
      pre[i] = 16'($urandom);
      doReq(1'b1, 16'(i * 2), pre[i]);
    end

    // Write then read-back latency on the LAT=3 unit
    cyc(1'b1, 1'b1, 16'h0024, 16'hBEEF, 1'b0);
    chk("wr_stall_c1", 0, 16'(bus3.stall), 16'h0001);
    idle();
    chk("wr_stall_c2", 0, 16'(bus3.stall), 16'h0001);
    idle();
    chk("wr_done_c3", 0, 16'(bus3.done), 16'h0001);
    chk("wr_data_c3", 0, bus3.data_out, 16'h0000);
    chk("wr_stall_c3", 0, 16'(bus3.stall), 16'h0000);
    doReq(1'b0, 16'h0024, 16'h0000);
    chk("rd_done_c6", 0, 16'(bus3.done), 16'h0001);
    chk("rd_data_c6", 0, bus3.data_out, 16'hBEEF);

    // Flush in first BUSY cycle
    cyc(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);
    chk("fl_stall", 0, 16'(bus3.stall), 16'h0001);
    cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    chk("fl_stall_off", 0, 16'(bus3.stall), 16'h0000);
    for (int i = 0; i < 3; i++) begin
      chk("fl_nodone", 0, 16'(bus3.done), 16'h0000);
      idle();
    end
    doReq(1'b0, 16'h0042, 16'h0000);
    chk("fl_next_done", 0, 16'(bus3.done), 16'h0001);
    chk("fl_next_data", 0, bus3.data_out, pre[33]);

    // Misaligned accesses
    doReq(1'b0, 16'h0025, 16'h0000);
    chk("mis_err", 0, 16'(bus3.err), 16'h0001);
    chk("mis_data", 0, bus3.data_out, 16'h0800);
    doReq(1'b1, 16'h0025, 16'h1111);
    chk("mis_wr_err", 0, 16'(bus3.err), 16'h0001);
    doReq(1'b0, 16'h0024, 16'h0000);
    chk("mis_intact", 0, bus3.data_out, 16'hBEEF);

    // Aliasing through ignored high address bits
    doReq(1'b1, 16'h0802, 16'h1234);
    doReq(1'b0, 16'h0002, 16'h0000);
    chk("alias", 0, bus3.data_out, 16'h1234);

    // Asynchronous reset in the middle of a write
    cyc(1'b1, 1'b1, 16'h0010, 16'h5555, 1'b0);
    rst = 1'b0;
    mReset(0); mReset(1);
    #1;
    chk("arst_stall", 0, 16'(bus3.stall), 16'h0000);
    chk("arst_done", 0, 16'(bus3.done), 16'h0000);
    chk("arst_err", 0, 16'(bus3.err), 16'h0000);
    chk("arst_data", 0, bus3.data_out, 16'h0000);
    chk("arst_data", 1, bus1.data_out, 16'h0000);
    idle(); idle();
    rst = 1'b1;
    idle();
    doReq(1'b0, 16'h0010, 16'h0000);
    chk("arst_kept", 0, bus3.data_out, pre[8]);

    // Back-to-back on the LAT=1 unit
    for (int i = 0; i < 8; i++) begin
      ri = 6'($urandom);
      cyc(1'b1, 1'b0, {9'h000, ri, 1'b0}, 16'h0000, 1'b0);
      chk("b2b_done", 1, 16'(bus1.done), 16'h0001);
      chk("b2b_stall", 1, 16'(bus1.stall), 16'h0000);
    end
    idle(); idle(); idle();
    cyc(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b1);
    chk("reqfl_done", 1, 16'(bus1.done), 16'h0000);
    chk("reqfl_stall", 0, 16'(bus3.stall), 16'h0000);
    idle(); idle();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        mReset(0); mReset(1);
        idle();
        rst = 1'b1;
      end
      ri = 6'($urandom);
      rh = 5'($urandom);
      ra = {rh, 4'b0000, ri, ($urandom_range(0, 7) == 0)};
      rd = 16'($urandom);
      cyc(($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 3), ra, rd,
          ($urandom_range(0, 9) == 0));
    end
    idle(); idle(); idle();

    $display("Result: errors=%0d of %0d checks", nErrs, nChecks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_mem_responder.md
# instr_mem_responder

Multi-cycle instruction-memory responder that serves the fetch stage's read requests in the pipelined WISC datapath, replacing the single-cycle ideal memory behind the PC register. It accepts one request at a time, holds the requester off with `stall` for a programmable latency, then returns the word with a one-cycle `done` pulse. A `flush` input lets fetch abandon an in-flight read on a taken branch. A write path lets the loader or testbench preload program images.

## Interface
- `ADDR_W`, default 10: word-address width. Array holds 2^ADDR_W 16-bit words.
- `LAT`, default 3: request-to-`done` latency in cycles. Legal range 1..15.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low. Asserting it forces IDLE immediately.
- `req`  in  1  request valid; sampled only in IDLE or DONE.
- `addr`  in  16  byte address of the request.
- `wr`  in  1  with `req`: 1 = write, 0 = read.
- `wdata`  in  16  write data, captured with the request.
- `flush`  in  1  abandons an in-flight read (fetch's doBranch).
- `data_out`  out  16  read data; valid when `done`=1.
- `done`  out  1  one-cycle completion pulse.
- `stall`  out  1  high while a request is in flight (BUSY).
- `err`  out  1  with `done`: request was misaligned.

## Operation
- States: IDLE, BUSY, DONE. All outputs are registered.
- Reset (`rst`=0): state=IDLE, `data_out`=0x0000, `done`=0, `stall`=0, `err`=0, and the latency counter is cleared. Array contents are not reset and are preserved. A write in flight is dropped.
- Accept condition: state is IDLE or DONE, `req`=1 and `flush`=0. On accept, `addr`, `wr` and `wdata` are captured.
  - If LAT=1, the next state is DONE.
  - Otherwise the next state is BUSY and the counter loads LAT-2.
- No accept: from DONE, go to IDLE; IDLE stays IDLE. A `req` with `flush`=1 is dropped.
- Word index = `addr[ADDR_W:1]`. Higher address bits are ignored, so addresses alias.
- Misaligned (`addr[0]`=1): the array is not accessed and nothing is written. Completion returns `data_out`=0x0800 (NOP) with `err`=1.
- BUSY:
  - `stall`=1.
  - The counter decrements each cycle. When it reaches 0, the next state is DONE.
  - `req`, `addr` and `wdata` are ignored in BUSY.
- `flush`=1 in BUSY on a read: the next state is IDLE, no `done` is produced and `stall` falls on the next cycle.
- `flush` does not affect writes; a write always completes.
- DONE (held for exactly one cycle):
  - `done`=1 and `stall`=0.
  - Aligned read: `data_out` = array word read at the captured address.
  - Write: the array is updated on entry to DONE and `data_out`=0x0000.
- Back-to-back: an accept while in DONE starts the next request immediately, with no idle bubble.
- `flush`=1 while in DONE does not suppress the visible `done` pulse. The requester ignores it. The state still returns to IDLE unless a new request is accepted.
- A read issued after a write to the same word returns the new data.

## Timing
- A request is sampled at edge k. `stall` is 1 in cycles k+1 .. k+LAT-1, and `done` is 1 in cycle k+LAT.
- With LAT=1, `stall` never asserts.
- Throughput: one request per LAT cycles when issued back-to-back from DONE.
- Flush at edge f while in BUSY: state is IDLE from cycle f+1, and `done` never pulses for that request.
- `data_out` holds its last value outside DONE, except reset, which clears it.
- Asynchronous reset asserts outputs to their reset values without waiting for a clock edge. Deassertion is assumed synchronized upstream.

## Test plan
- Reset: hold `rst`=0 mid-BUSY → `stall`, `done`, `err` go to 0 and `data_out`=0x0000 immediately. Release, then read 0x0010 → data previously written there is intact.
- Write/read latency, LAT=3:
  - Write 0xBEEF to 0x0024 at edge 0 → `stall`=1 in cycles 1–2, `done`=1 in cycle 3 with `data_out`=0x0000.
  - Read 0x0024 issued from DONE → `done` in cycle 6 with `data_out`=0xBEEF.
- Flush: read 0x0040, assert `flush` in the first BUSY cycle → no `done`, `stall`=0 the next cycle. A new read of 0x0042 then completes normally after 3 cycles.
- Misaligned: read 0x0025 → `done`=1, `err`=1, `data_out`=0x0800. A following write to 0x0025 leaves word 0x0024 = 0xBEEF.
- Aliasing, ADDR_W=10: write 0x1234 to 0x0802, then read 0x0002 → returns 0x1234.
- LAT=1 and overlaps:
  - Back-to-back reads every cycle → `done` every cycle and `stall` never asserts.
  - `req` with `flush` in IDLE → request ignored.
